lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator. It replaces the fixed 8-bit counter and provides configurable width and tap mask, seed load, a step enable, and wrap detection with period measurement. It also flags the XNOR lock-up state. It feeds FIFO test-pattern generators and address scramblers in the FIFO datapath.

---
 rtl/lfsr_gen.sv | 95 +++++++++
 tb/tb_lfsr_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Fibonacci XNOR LFSR with seed load, wrap detection, period measurement and lock-up flag.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (an EN step out of all-ones restarts at zero).
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h88
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED,
    output logic [WIDTH-1:0] lfsr_count,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic             fb;
    logic [WIDTH-1:0] next;

    assign fb   = ~^(lfsr_q & TAPS);
    assign next = {lfsr_q[WIDTH-2:0], fb};

    always_comb begin
        lfsr_d   = lfsr_q;
        start_d  = start_q;
        step_d   = step_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = lockup_q;
        if (LOAD) begin
            lfsr_d   = SEED;
            start_d  = SEED;
            step_d   = '0;
            period_d = '0;
            lockup_d = (SEED == ONES);
        end else if (EN) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (lfsr_q == ONES) begin
                lfsr_d   = '0;
                start_d  = '0;
                step_d   = '0;
                period_d = '0;
                lockup_d = 1'b0;
            end else begin
`else
            begin
`endif
                lfsr_d   = next;
                lockup_d = (next == ONES);
                // Returning to start closes a loop; step_q+1 cannot overflow WIDTH bits.
                if (next == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = step_q + ONE;
                    step_d   = '0;
                end else begin
                    step_d   = step_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr_q   <= '0;
            start_q  <= '0;
            step_q   <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            start_q  <= start_d;
            step_q   <= step_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign lfsr_count = lfsr_q;
    assign wrap       = wrap_q;
    assign period     = period_q;
    assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed test-plan steps plus random traffic against a history-based model.
module tb_lfsr_gen;

    localparam logic [3:0] TAPS4 = 4'hC;

    logic       CLK = 1'b0;
    logic       r = 1'b1, l = 1'b0, e = 1'b0;
    logic [3:0] s4 = '0;
    logic [7:0] s8 = '0;
    logic [7:0] c8, p8;
    logic       w8, k8;
    logic [3:0] c4, p4;
    logic       w4, k4;

    int checks = 0;
    int failures = 0;

    // Model state: history of states visited since the start value
    logic [3:0] m_lfsr, m_start, m_period;
    logic       m_wrap, m_lockup;
    logic [3:0] hist[$];

    always #5 CLK = ~CLK;

    lfsr_gen #(.WIDTH(8), .TAPS(8'h88)) u8 (
        .CLK(CLK), .RESET(r), .EN(e), .LOAD(l), .SEED(s8),
        .lfsr_count(c8), .wrap(w8), .period(p8), .lockup(k8)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC)) u4 (
        .CLK(CLK), .RESET(r), .EN(e), .LOAD(l), .SEED(s4),
        .lfsr_count(c4), .wrap(w4), .period(p4), .lockup(k4)
    );

    function automatic logic [3:0] mnext(logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) if (s[i] && TAPS4[i]) n++;
        return 4'((int'(s) * 2) % 16 + ((n % 2 == 0) ? 1 : 0));
    endfunction

    task automatic model_step(logic rr, logic ll, logic ee, logic [3:0] ss);
        logic [3:0] nx;
        if (rr) begin
            m_lfsr = 0; m_start = 0; m_period = 0; m_wrap = 0; m_lockup = 0; hist.delete();
        end else if (ll) begin
            m_lfsr = ss; m_start = ss; m_period = 0; m_wrap = 0; m_lockup = (ss == 4'hF); hist.delete();
        end else if (ee) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (m_lfsr == 4'hF) begin
                m_lfsr = 0; m_start = 0; m_period = 0; m_wrap = 0; m_lockup = 0; hist.delete();
                return;
            end
`endif
            nx = mnext(m_lfsr);
            if (nx == m_start) begin
                m_period = 4'(hist.size() + 1);
                m_wrap = 1;
                hist.delete();
            end else begin
                hist.push_back(nx);
                m_wrap = 0;
            end
            m_lfsr = nx;
            m_lockup = (nx == 4'hF);
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".cnt"}, 32'(c4), 32'(m_lfsr));
        chk({tag, ".wrap"}, 32'(w4), 32'(m_wrap));
        chk({tag, ".period"}, 32'(p4), 32'(m_period));
        chk({tag, ".lockup"}, 32'(k4), 32'(m_lockup));
    endtask

    task automatic cyc(logic rr, logic ll, logic ee, logic [3:0] ss);
        @(negedge CLK);
        r = rr; l = ll; e = ee; s4 = ss; s8 = {4'h0, ss};
        @(posedge CLK);
        model_step(rr, ll, ee, ss);
        #1;
    endtask

    initial begin
        logic [7:0] exp8 [5];
        logic [15:0] seen;
        logic [3:0] hc, hp;
        logic hk;
        exp8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};

        // Reset state and 8-bit sequence
        cyc(1, 0, 0, 0);
        chk("rst8.cnt", 32'(c8), 0); chk("rst8.wrap", 32'(w8), 0);
        chk("rst8.period", 32'(p8), 0); chk("rst8.lockup", 32'(k8), 0);
        chk_model("rst4");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0);
            chk("seq8.cnt", 32'(c8), 32'(exp8[i]));
            chk("seq8.wrap", 32'(w8), 0);
            chk("seq8.lockup", 32'(k8), 0);
            chk_model("seq4");
        end

        // Full period from reset; visited states must be distinct and never F
        cyc(1, 0, 0, 0);
        seen = '0;
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 0);
            chk_model("per");
            chk("per.distinct", 32'(seen[c4]), 0);
            chk("per.notF", 32'(c4 == 4'hF), 0);
            seen[c4] = 1'b1;
            chk("per.wrapstep", 32'(w4), 32'(i == 15));
        end
        chk("per.period", 32'(p4), 15);
        chk("per.cnt", 32'(c4), 0);

        // LOAD beats EN, then loop back to the seed
        cyc(0, 1, 1, 4'h5);
        chk("ld.cnt", 32'(c4), 5); chk("ld.period", 32'(p4), 0); chk("ld.wrap", 32'(w4), 0);
        chk_model("ld");
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 0);
            chk_model("ldrun");
        end
        chk("ldrun.wrap", 32'(w4), 1); chk("ldrun.cnt", 32'(c4), 5); chk("ldrun.period", 32'(p4), 15);

        // Lock-up
        cyc(0, 1, 0, 4'hF);
        chk("lk.lockup", 32'(k4), 1); chk_model("lk");
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0);
            chk_model("lken");
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (i == 0) begin
                chk("lkrec.cnt", 32'(c4), 0); chk("lkrec.lockup", 32'(k4), 0);
            end
`else
            chk("lkfix.cnt", 32'(c4), 4'hF); chk("lkfix.wrap", 32'(w4), 1);
            chk("lkfix.period", 32'(p4), 1); chk("lkfix.lockup", 32'(k4), 1);
`endif
        end

        // Reset mid-run discards the partial count
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("mid.cnt", 32'(c4), 0); chk("mid.period", 32'(p4), 0);
        chk("mid.wrap", 32'(w4), 0); chk("mid.lockup", 32'(k4), 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        chk("mid.wrap15", 32'(w4), 1); chk("mid.period15", 32'(p4), 15); chk_model("mid");

        // Hold
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        hc = c4; hp = p4; hk = k4;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 4'(i));
            chk("hold.cnt", 32'(c4), 32'(hc)); chk("hold.period", 32'(p4), 32'(hp));
            chk("hold.lockup", 32'(k4), 32'(hk)); chk("hold.wrap", 32'(w4), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int pr;
            pr = $urandom_range(0, 99);
            cyc(pr < 2, (pr >= 2 && pr < 8), ($urandom_range(0, 99) < 75), 4'($urandom));
            chk_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
